// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ST_W = 2;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [ST_W-1:0] fetch_state_t;

    localparam word_t DEF_RESET_PC  = 32'h0000_0000;
    localparam word_t DEF_NOP_INSTR = 32'h0000_0000;

    // Fetch FSM state enumeration
    localparam fetch_state_t ST_BOOT       = 2'd0;
    localparam fetch_state_t ST_RUN        = 2'd1;
    localparam fetch_state_t ST_MISS       = 2'd2;
    localparam fetch_state_t ST_MISS_REDIR = 2'd3;

    // IF/ID pipeline register payload
    typedef struct packed {
        word_t instr;
        word_t pcplus4;
        logic  valid;
    } ifid_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic word_t sat_inc(input word_t val, input logic en);
        return (en && (val != {XLEN{1'b1}})) ? val + XLEN'(1) : val;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority (EX JR > EX branch > D jump) and target alignment.
module pc_next_sel
    import pipe_pkg::*;
(
    input  logic  [XLEN-1:0] pc,
    input  logic             pc_enable,
    input  logic             branch_taken,
    input  logic  [XLEN-1:0] branch_target,
    input  logic             jr,
    input  logic  [XLEN-1:0] jr_target,
    input  logic             jump,
    input  logic  [XLEN-1:0] jump_target,
    output logic             ex_redir_c,
    output logic             d_redir_c,
    output logic  [XLEN-1:0] redir_target_c,
    output logic  [XLEN-1:0] seq_pc_c
);

    always_comb begin
        ex_redir_c = jr | branch_taken;
        // A D-stage jump is only honoured when the pipe is advancing and EX is quiet
        d_redir_c  = jump & pc_enable & ~ex_redir_c;
        if (jr) begin
            redir_target_c = align_word(jr_target);
        end else if (branch_taken) begin
            redir_target_c = align_word(branch_target);
        end else begin
            redir_target_c = align_word(jump_target);
        end
        seq_pc_c = pc + XLEN'(4);
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC ownership, I-cache fetch handshake, redirects.
// Optional FETCH_PERF_CNT_EN adds miss-cycle and redirect counters.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter word_t RESET_PC  = DEF_RESET_PC,
    parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iPCEnable,
    input  logic            iflushifdec,
    input  logic            iBranchTaken,
    input  logic [XLEN-1:0] iBranchTarget,
    input  logic            iJR_RegE,
    input  logic [XLEN-1:0] iJRTarget,
    input  logic            iJump,
    input  logic [XLEN-1:0] iJumpTarget,
    output logic            oICacheRead,
    output logic [XLEN-1:0] oICacheAddr,
    input  logic [XLEN-1:0] iICacheRdata,
    input  logic            iICacheStall,
    output logic [XLEN-1:0] oInstruction_RegD,
    output logic [XLEN-1:0] oPCPlus4_RegD,
    output logic            oValid_RegD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] oMissCycles,
    output logic [XLEN-1:0] oRedirects
`endif
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_tgt_q, pend_tgt_d;
    logic         pend_ex_q, pend_ex_d;
    logic         read_q, read_d;
    ifid_t        ifid_q, ifid_d;
    logic         fetched_c;

    logic  ex_redir_c, d_redir_c;
    word_t redir_target_c, seq_pc_c;

    pc_next_sel u_pc_next_sel (
        .pc             (pc_q),
        .pc_enable      (iPCEnable),
        .branch_taken   (iBranchTaken),
        .branch_target  (iBranchTarget),
        .jr             (iJR_RegE),
        .jr_target      (iJRTarget),
        .jump           (iJump),
        .jump_target    (iJumpTarget),
        .ex_redir_c     (ex_redir_c),
        .d_redir_c      (d_redir_c),
        .redir_target_c (redir_target_c),
        .seq_pc_c       (seq_pc_c)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_ex_d  = pend_ex_q;
        fetched_c  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_MISS: begin
                if (ex_redir_c || d_redir_c) begin
                    if (iICacheStall) begin
                        state_d    = ST_MISS_REDIR;
                        pend_tgt_d = redir_target_c;
                        pend_ex_d  = ex_redir_c;
                    end else begin
                        // A redirect landing as a miss resolves discards that word
                        state_d   = ST_RUN;
                        pc_d      = redir_target_c;
                        fetched_c = (state_q == ST_RUN);
                    end
                end else if (iICacheStall) begin
                    state_d = ST_MISS;
                end else begin
                    state_d   = ST_RUN;
                    fetched_c = 1'b1;
                    if (iPCEnable) begin
                        pc_d = seq_pc_c;
                    end
                end
            end
            ST_MISS_REDIR: begin
                if (ex_redir_c) begin
                    pend_tgt_d = redir_target_c;
                    pend_ex_d  = 1'b1;
                end else if (d_redir_c && !pend_ex_q) begin
                    pend_tgt_d = redir_target_c;
                    pend_ex_d  = 1'b0;
                end
                if (!iICacheStall) begin
                    state_d    = ST_RUN;
                    pc_d       = pend_tgt_d;
                    pend_tgt_d = '0;
                    pend_ex_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        read_d = (state_d != ST_BOOT);

        if (iflushifdec) begin
            ifid_d = BUBBLE;
        end else if (!iPCEnable) begin
            ifid_d = ifid_q;
        end else if (fetched_c) begin
            ifid_d = '{instr: iICacheRdata, pcplus4: seq_pc_c, valid: 1'b1};
        end else begin
            ifid_d = BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_ex_q  <= 1'b0;
            read_q     <= 1'b0;
            ifid_q     <= BUBBLE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_ex_q  <= pend_ex_d;
            read_q     <= read_d;
            ifid_q     <= ifid_d;
        end
    end

    assign oICacheRead       = read_q;
    assign oICacheAddr       = pc_q;
    assign oInstruction_RegD = ifid_q.instr;
    assign oPCPlus4_RegD     = ifid_q.pcplus4;
    assign oValid_RegD       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    word_t miss_cnt_q, miss_cnt_d;
    word_t redir_cnt_q, redir_cnt_d;
    logic  redir_applied_c;

    // A D jump in MISS_REDIR that cannot displace a pending EX target is not applied
    always_comb begin
        redir_applied_c = (state_q != ST_BOOT) &&
                          (ex_redir_c ||
                           (d_redir_c && !((state_q == ST_MISS_REDIR) && pend_ex_q)));
        miss_cnt_d  = sat_inc(miss_cnt_q,
                              (state_q == ST_MISS) || (state_q == ST_MISS_REDIR));
        redir_cnt_d = sat_inc(redir_cnt_q, redir_applied_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_cnt_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign oMissCycles = miss_cnt_q;
    assign oRedirects  = redir_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and issues instruction-fetch requests to the I-cache over a stall handshake.
- Applies redirects from EX (taken branch, JR) and from D (J/JAL).
- Consumes the hazard unit's PC-enable and IF/ID-flush controls and presents the fetched instruction to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on a bubble or flush.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- iPCEnable  in  1  from hazard unit; 0 = load-use stall, hold PC and IF/ID.
- iflushifdec  in  1  from hazard unit; turn IF/ID into a bubble.
- iBranchTaken  in  1  EX: branch taken (Branch & zero).
- iBranchTarget  in  32  EX branch target.
- iJR_RegE  in  1  EX: JR executing.
- iJRTarget  in  32  EX register-source target.
- iJump  in  1  D: J or JAL decoded.
- iJumpTarget  in  32  D jump target.
- oICacheRead  out  1  fetch request valid.
- oICacheAddr  out  32  fetch address (= PC).
- iICacheRdata  in  32  instruction word, valid when iICacheStall=0.
- iICacheStall  in  1  1 = miss in progress; rdata invalid.
- oInstruction_RegD  out  32  IF/ID instruction.
- oPCPlus4_RegD  out  32  IF/ID PC+4 (JAL link, branch base).
- oValid_RegD  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0 at posedge): PC=RESET_PC, state=BOOT, pending cleared, oInstruction_RegD=NOP_INSTR, oPCPlus4_RegD=0, oValid_RegD=0, oICacheRead=0. Applies mid-miss too; any pending redirect is discarded.
- FSM states: BOOT, RUN, MISS, MISS_REDIR.
- BOOT: one cycle with no request, then RUN.
- RUN:
  - oICacheRead=1, oICacheAddr=PC.
  - iICacheStall=1 -> MISS.
  - Otherwise the fetch completes this cycle and redirect selection applies.
- Redirect priority: EX over D over sequential.
  - EX: JR over branch. JR -> iJRTarget; branch -> iBranchTarget.
  - D: iJump -> iJumpTarget.
  - Sequential: PC+4.
- Targets have bits[1:0] forced to 0.
- PC+4 wraps modulo 2^32.
- PC update:
  - An EX redirect updates PC even when iPCEnable=0, because the stalled D instruction is being flushed.
  - A D redirect or sequential advance occurs only when iPCEnable=1.
- IF/ID update, first matching rule wins:
  - iflushifdec=1 -> {NOP_INSTR, 0, valid 0}.
  - iPCEnable=0 -> hold all three.
  - Fetch completed -> {iICacheRdata, PC+4, 1}.
  - Otherwise (miss) -> bubble {NOP_INSTR, 0, 0}.
- MISS:
  - PC, oICacheRead=1 and oICacheAddr are held stable.
  - Any redirect arriving here latches the selected target into pending and moves to MISS_REDIR.
  - When stall drops with no redirect, the fetch completes as in RUN; then back to RUN.
- MISS_REDIR:
  - Address is held (the cache transaction must finish).
  - A later EX redirect overwrites the pending target; a D redirect never overwrites an EX one.
  - When stall drops: discard rdata, insert a bubble, PC=pending target, clear pending, go to RUN.
- Simultaneous stall drop and redirect in MISS: the redirect wins, the fetched word is discarded, and PC takes the new target next cycle.
- Latency: a redirect at cycle N gives oICacheAddr=target at N+1. A hit gives IF/ID valid at the edge ending the fetch cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs oMissCycles (32) and oRedirects (32).
  - oMissCycles counts cycles with state in {MISS, MISS_REDIR}.
  - oRedirects counts cycles with an applied EX or D redirect.
  - Both cleared by reset; both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - FSM state enum (BOOT/RUN/MISS/MISS_REDIR).
  - NOP_INSTR constant.
  - RESET_PC default.
  - 32-bit word typedef.
- One sub-module, pc_next_sel: the combinational redirect priority/alignment mux.

Test Plan:
- Reset then hits at 0x0,0x4,0x8 -> BOOT one cycle; oICacheAddr 0x0,0x4,0x8 on consecutive cycles; oValid_RegD=1 with oPCPlus4_RegD 0x4,0x8,0xC.
- iPCEnable=0 for 2 cycles at PC=0x10 -> PC and IF/ID held; oICacheAddr stays 0x10.
- iBranchTaken=1, target 0x100, with iPCEnable=0 and iflushifdec=1 in the same cycle -> next oICacheAddr=0x100; oValid_RegD=0 with NOP.
- Same cycle iJR_RegE (0x200), iBranchTaken (0x300) and iJump (0x400) -> next PC=0x200.
- Miss at 0x20 for 3 cycles, iJump target 0x80 in the 2nd -> address stays 0x20 until stall drops; that word is discarded; next address 0x80; bubbles in IF/ID throughout.
- rst_n=0 during MISS_REDIR -> next cycle BOOT, PC=RESET_PC, pending cleared, oICacheRead=0; with FETCH_PERF_CNT_EN both counters read 0.
